// File: rtl/pixel_array_ctrl.sv
// rtl/pixel_array_ctrl.sv - frame sequencer for a 4-pixel array with Gray ramp ADC and readout
module pixel_array_ctrl #(
  parameter int ERASE_CYCLES  = 5,
  parameter int EXPOSE_CYCLES = 255,
  parameter int COUNT_MAX     = 255,
  parameter int READ_SETTLE   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       busy,
  output logic       erase,
  output logic       expose,
  output logic       convert,
  output logic [3:0] read,
  inout  wire  [7:0] pixData,
  output logic [7:0] out_data,
  output logic [1:0] out_pix,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       frame_done
);

  typedef enum logic [2:0] {
    IDLE, ERASE, EXPOSE, CONVERT, RD_SEL, RD_OUT, DONE
  } state_t;

  localparam logic [15:0] ERASE_LAST  = 16'(ERASE_CYCLES - 1);
  localparam logic [15:0] EXPOSE_LAST = 16'(EXPOSE_CYCLES - 1);
  localparam logic [15:0] CONV_LAST   = 16'(COUNT_MAX);
  localparam logic [15:0] SETTLE_LAST = 16'(READ_SETTLE - 1);

  state_t      state, stateNext;
  logic [15:0] cnt, cntNext;
  logic [1:0]  pixIdx, pixIdxNext;
  logic [7:0]  dataReg, dataNext;
  logic [7:0]  rampGray;
  logic [7:0]  decoded;
  logic        acc;

  assign rampGray = cnt[7:0] ^ {1'b0, cnt[7:1]};
  assign pixData  = (state == CONVERT) ? rampGray : 8'bz;

  // Gray to binary: each binary bit is the XOR of all Gray bits at or above it
  always_comb begin
    decoded = '0;
    acc     = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      acc        = acc ^ pixData[k];
      decoded[k] = acc;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pixIdx  <= '0;
      dataReg <= '0;
    end else begin
      state   <= stateNext;
      cnt     <= cntNext;
      pixIdx  <= pixIdxNext;
      dataReg <= dataNext;
    end
  end

  always_comb begin
    stateNext  = state;
    cntNext    = cnt;
    pixIdxNext = pixIdx;
    dataNext   = dataReg;
    busy       = (state != IDLE);
    erase      = 1'b0;
    expose     = 1'b0;
    convert    = 1'b0;
    read       = 4'b0000;
    out_valid  = 1'b0;
    frame_done = 1'b0;
    out_data   = dataReg;
    out_pix    = pixIdx;
    case (state)
      IDLE: begin
        if (start) begin
          stateNext  = ERASE;
          cntNext    = '0;
          pixIdxNext = '0;
        end
      end
      ERASE: begin
        erase = 1'b1;
        if (cnt == ERASE_LAST) begin
          cntNext   = '0;
          stateNext = EXPOSE;
        end else begin
          cntNext = cnt + 16'd1;
        end
      end
      EXPOSE: begin
        expose = 1'b1;
        if (cnt == EXPOSE_LAST) begin
          cntNext   = '0;
          stateNext = CONVERT;
        end else begin
          cntNext = cnt + 16'd1;
        end
      end
      CONVERT: begin
        convert = 1'b1;
        // leave on the COUNT_MAX cycle so the ramp never wraps back to 0 on the bus
        if (cnt == CONV_LAST) begin
          cntNext   = '0;
          stateNext = RD_SEL;
        end else begin
          cntNext = cnt + 16'd1;
        end
      end
      RD_SEL: begin
        read = 4'b0001 << pixIdx;
        if (cnt == SETTLE_LAST) begin
          dataNext  = decoded;
          cntNext   = '0;
          stateNext = RD_OUT;
        end else begin
          cntNext = cnt + 16'd1;
        end
      end
      RD_OUT: begin
        out_valid = 1'b1;
        if (out_ready) begin
          pixIdxNext = pixIdx + 2'd1;
          stateNext  = (pixIdx == 2'd3) ? DONE : RD_SEL;
        end
      end
      DONE: begin
        frame_done = 1'b1;
        stateNext  = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

endmodule

// File: tb/tb_pixel_array_ctrl.sv
// tb/tb_pixel_array_ctrl.sv - timeline model and pixel array model bench for pixel_array_ctrl
module tb_pixel_array_ctrl;
  localparam int E   = 5;
  localparam int X   = 255;
  localparam int CM  = 255;
  localparam int S   = 2;
  localparam int C   = CM + 1;
  localparam int RD0 = E + X + C + 1;

  logic       clk = 1'b0;
  logic       reset, start, out_ready;
  logic       busy, erase, expose, convert, out_valid, frame_done;
  logic [3:0] read;
  wire  [7:0] pixData;
  logic [7:0] out_data;
  logic [1:0] out_pix;

  always #5 clk = ~clk;

  pixel_array_ctrl #(.ERASE_CYCLES(E), .EXPOSE_CYCLES(X), .COUNT_MAX(CM), .READ_SETTLE(S)) dut (
    .clk(clk), .reset(reset), .start(start), .busy(busy), .erase(erase), .expose(expose),
    .convert(convert), .read(read), .pixData(pixData), .out_data(out_data), .out_pix(out_pix),
    .out_valid(out_valid), .out_ready(out_ready), .frame_done(frame_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  // Behavioural pixel array: each pixel latches the bus at its target ramp step
  logic [7:0] target[4];
  logic [7:0] latched[4];
  logic [7:0] arrVal;
  int rampIdx = 0;

  always @(negedge clk) begin
    if (convert) begin
      for (int i = 0; i < 4; i++)
        if (rampIdx == int'(target[i])) latched[i] = pixData;
      rampIdx++;
    end else begin
      rampIdx = 0;
    end
  end

  always_comb begin
    arrVal = '0;
    for (int i = 0; i < 4; i++)
      if (read[i]) arrVal = latched[i];
  end

  assign pixData = (read != 4'b0000) ? arrVal : 8'bz;

  // Timeline model: mK counts edges since the accepted start edge
  bit   mActive = 0;
  int   mK, mPix, mRdStart, mDoneAt;
  int   firstValidLat, eraseHigh, exposeHigh, convHigh;
  int   fdCount = 0;
  logic [7:0] firstGray, lastGray, prevGray;
  bit   inConv;
  logic [9:0] hsQ[$];

  always @(negedge clk) begin
    bit eErase, eExpose, eConv, eValid, eDone;
    logic [3:0] eRead;
    int v;
    if (!reset) begin
      mActive = 0;
      chk("reset_outputs", int'({busy, erase, expose, convert, read, out_valid, frame_done, out_pix, out_data}), 0);
    end else begin
      if (mActive) begin
        eErase  = (mK <= E);
        eExpose = (mK > E) && (mK <= E + X);
        eConv   = (mK > E + X) && (mK <= E + X + C);
        eRead   = 4'b0000;
        eValid  = 0;
        eDone   = 0;
        if (mDoneAt != 0 && mK == mDoneAt) eDone = 1;
        else if (mK >= mRdStart) begin
          if (mK < mRdStart + S) eRead = 4'(1 << mPix);
          else eValid = 1;
        end
        chk("busy", int'(busy), 1);
        chk("erase", int'(erase), int'(eErase));
        chk("expose", int'(expose), int'(eExpose));
        chk("convert", int'(convert), int'(eConv));
        chk("read", int'(read), int'(eRead));
        chk("out_valid", int'(out_valid), int'(eValid));
        chk("frame_done", int'(frame_done), int'(eDone));
        if (eConv) begin
          v = mK - E - X - 1;
          chk("ramp_bus", int'(pixData), (v ^ (v >> 1)) & 255);
        end
        if (eValid) begin
          chk("out_pix", int'(out_pix), mPix);
          chk("out_data", int'(out_data), int'(target[mPix]));
          if (firstValidLat == 0) firstValidLat = mK;
        end
        if (mDoneAt != 0 && mK == mDoneAt) mActive = 0;
        else if (eValid && out_ready) begin
          if (mPix == 3) mDoneAt = mK + 1;
          else begin
            mPix++;
            mRdStart = mK + 1;
          end
        end
        mK++;
      end else begin
        chk("idle_outputs", int'({busy, erase, expose, convert, read, out_valid, frame_done}), 0);
        if (start) begin
          mActive = 1; mK = 1; mPix = 0; mRdStart = RD0; mDoneAt = 0;
          firstValidLat = 0; eraseHigh = 0; exposeHigh = 0; convHigh = 0;
          inConv = 0;
          hsQ.delete();
        end
      end
      if (erase) eraseHigh++;
      if (expose) exposeHigh++;
      if (convert) begin
        convHigh++;
        if (inConv) chk("gray_step", $countones(prevGray ^ pixData), 1);
        else firstGray = pixData;
        prevGray = pixData;
        lastGray = pixData;
        inConv = 1;
      end else begin
        inConv = 0;
      end
      if (frame_done) fdCount++;
      if (out_valid && out_ready) hsQ.push_back({out_pix, out_data});
    end
  end

  task automatic runFrame(input int mode);
    int n, stall, fd0;
    bit s1, s2;
    fd0 = fdCount; stall = 0; s1 = 0; s2 = 0;
    @(posedge clk); #2;
    start = 1'b1;
    out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    while (fdCount == fd0 && n < 5000) begin
      case (mode)
        1: begin
          if (out_valid && out_pix == 2'd1 && stall < 50) begin
            out_ready = 1'b0;
            stall++;
          end else begin
            if (stall == 50) begin
              chk("stall_valid_held", int'(out_valid), 1);
              chk("stall_pix_held", int'(out_pix), 1);
              stall++;
            end
            out_ready = 1'b1;
          end
        end
        2: out_ready = 1'($urandom_range(0, 1));
        3: begin
          out_ready = 1'b1;
          start = 1'b0;
          if (expose && !s1) begin start = 1'b1; s1 = 1; end
          else if (out_valid && !s2) begin start = 1'b1; s2 = 1; end
        end
        default: out_ready = 1'b1;
      endcase
      @(posedge clk); #2;
      n++;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    chk("frame_done_count", fdCount - fd0, 1);
    chk("busy_after_frame", int'(busy), 0);
    chk("handshake_count", hsQ.size(), 4);
    for (int i = 0; i < 4; i++)
      if (hsQ.size() > i) chk("handshake_order", int'(hsQ[i]), (i << 8) | int'(target[i]));
    if (mode == 1) chk("stall_reached", stall, 51);
    if (mode == 3) chk("stray_starts_driven", int'(s1 && s2), 1);
  endtask

  initial begin
    int n, fdBefore;
    reset = 1'b0; start = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) target[i] = '0;
    repeat (3) @(posedge clk);
    #2 reset = 1'b1;
    repeat (20) @(posedge clk);
    #2;
    chk("idle_busy_literal", int'(busy), 0);
    chk("idle_read_literal", int'(read), 0);

    target[0] = 8'd10; target[1] = 8'd100; target[2] = 8'd200; target[3] = 8'd255;
    runFrame(0);
    chk("erase_cycles", eraseHigh, 5);
    chk("expose_cycles", exposeHigh, 255);
    chk("convert_cycles", convHigh, 256);
    chk("first_valid_latency", firstValidLat, 519);
    chk("gray_first", int'(firstGray), 8'h00);
    chk("gray_last", int'(lastGray), 8'h80);
    if (hsQ.size() == 4) begin
      chk("nominal_pix0", int'(hsQ[0]), 10);
      chk("nominal_pix1", int'(hsQ[1]), 256 + 100);
      chk("nominal_pix2", int'(hsQ[2]), 512 + 200);
      chk("nominal_pix3", int'(hsQ[3]), 768 + 255);
    end

    for (int i = 0; i < 4; i++) target[i] = 8'($urandom_range(0, 255));
    runFrame(1);

    for (int i = 0; i < 4; i++) target[i] = 8'($urandom_range(0, 255));
    runFrame(3);

    fdBefore = fdCount;
    @(posedge clk); #2;
    start = 1'b1; out_ready = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(convert && pixData == 8'h37) && n < 2000);
    chk("reached_cnt37", int'(convert && pixData == 8'h37), 1);
    #1 reset = 1'b0;
    #1;
    chk("abort_convert", int'(convert), 0);
    chk("abort_busy", int'(busy), 0);
    chk("abort_read", int'(read), 0);
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("abort_no_frame_done", fdCount - fdBefore, 0);

    for (int f = 0; f < 3; f++) begin
      for (int i = 0; i < 4; i++) target[i] = 8'($urandom_range(0, 255));
      runFrame(2);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_array_ctrl.md
Name: pixel_array_ctrl

Overview:
- Sequencer that sits directly upstream of the 4-pixel array and consumes its shared 8-bit data bus.
- Runs one frame per start pulse: erase, expose, then ADC conversion. During conversion it drives a Gray-coded ramp counter onto the shared bus.
- Then reads the 4 pixels out one at a time, Gray-to-binary decodes each value, and delivers it downstream over a valid/ready handshake.

Parameters:
- ERASE_CYCLES, 5: cycles erase is held high; legal range 1..255.
- EXPOSE_CYCLES, 255: cycles expose is held high; legal range 1..65535.
- COUNT_MAX, 255: last counter value driven during conversion; conversion lasts COUNT_MAX+1 cycles.
- READ_SETTLE, 2: cycles read[i] is held before pixData is sampled; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle frame request; sampled only in IDLE.
- busy  out  1  high in every state except IDLE.
- erase  out  1  pixel erase, common to all pixels.
- expose  out  1  pixel expose, common to all pixels.
- convert  out  1  high during CONVERT; enables the analog ramp.
- read  out  4  one-hot per-pixel read select; read[i] selects pixel i.
- pixData  inout  8  shared pixel bus; driven by this block only in CONVERT, hi-Z otherwise.
- out_data  out  8  decoded binary pixel value.
- out_pix  out  2  index of the pixel in out_data.
- out_valid  out  1  out_data and out_pix are valid.
- out_ready  in  1  downstream accepts when out_valid and out_ready are both high.
- frame_done  out  1  one-cycle pulse after the 4th pixel transfer.

Behaviour:
- Reset (asynchronous, active-low): FSM goes to IDLE, all counters clear, pixData goes hi-Z.
  - Every output is 0: busy, erase, expose, convert, read, out_data, out_pix, out_valid, frame_done.
  - Reset asserted mid-frame aborts the frame immediately; no partial frame_done is produced.
- States: IDLE -> ERASE -> EXPOSE -> CONVERT -> RD_SEL -> RD_OUT -> (RD_SEL | DONE) -> IDLE.
- IDLE: start=1 -> ERASE on the next edge. start in any other state is ignored, not queued.
- ERASE:
  - erase=1 for exactly ERASE_CYCLES cycles, then EXPOSE.
  - erase and expose are never high in the same cycle.
- EXPOSE: expose=1 for exactly EXPOSE_CYCLES cycles, then CONVERT.
- CONVERT:
  - 8-bit counter cnt starts at 0 and increments every cycle; pixData = cnt ^ (cnt>>1); convert=1.
  - After the cycle with cnt=COUNT_MAX: go to RD_SEL, release pixData, drop convert.
  - Exactly COUNT_MAX+1 bus values are driven; no wrap to 0 is ever driven.
- RD_SEL (pixel index p, starting at 0):
  - read = 1<<p for READ_SETTLE cycles.
  - On the last of those cycles, register pixData and Gray-decode it: b[7]=g[7], b[k]=b[k+1]^g[k].
  - Then go to RD_OUT with read=0.
- RD_OUT:
  - out_valid=1, out_pix=p; out_data is held stable until the handshake.
  - Handshake (out_valid & out_ready): p increments. p<3 -> RD_SEL; p=3 -> DONE.
  - out_ready held low stalls indefinitely with all outputs held.
  - out_ready high before out_valid has no effect.
- DONE: frame_done=1 for one cycle, then IDLE.
  - start in the DONE cycle is ignored; start is accepted from the next IDLE cycle.
- Mutual exclusion:
  - read is never nonzero while pixData is driven.
  - At most one read bit is high at any time.
  - out_valid is never high outside RD_OUT.
- Latency from the start edge to the first out_valid: ERASE_CYCLES + EXPOSE_CYCLES + COUNT_MAX+1 + READ_SETTLE + 1 cycles.

Test Plan:
- Reset then idle: hold reset low 3 cycles, release, no start -> all outputs 0, pixData hi-Z, busy=0 for 20 cycles.
- Nominal frame with defaults (pixels from a behavioural array model latching at counts 10, 100, 200, 255), out_ready=1:
  - erase high 5 cycles, expose high 255 cycles, convert high 256 cycles.
  - Outputs, in order: (pix0, 10), (pix1, 100), (pix2, 200), (pix3, 255).
  - frame_done pulses once; first out_valid lands 519 cycles after start.
- Gray bus check: monitor pixData during CONVERT -> consecutive values differ by exactly 1 bit; first value 0x00, last value 0x80 (Gray of 255).
- Backpressure: out_ready=0 for 50 cycles while pix1 is valid -> out_valid, out_data, out_pix stable and read=0 throughout; releasing out_ready resumes with pix2.
- start pulses during EXPOSE and during RD_OUT -> ignored: exactly one frame_done, and busy drops after the frame.
- Reset asserted mid-CONVERT at cnt=37 -> the same cycle pixData goes hi-Z, convert=0, busy=0; a new start then runs a complete frame.
